mem_access_ctrl: RTL and testbench

Sequences data-memory loads and stores for the instruction waiting at the execute→memory boundary. It drives a request/acknowledge data-memory port and formats load data. It produces the memory_ready / valM pair consumed by the memory pipeline register, and the allow-in back-pressure seen by the execute stage. Transactions are multi-cycle; the block holds completed results until write-back accepts them.

---
 rtl/mem_access_ctrl_pkg.sv | 32 +++
 rtl/mem_access_ctrl_if.sv | 31 +++
 rtl/mem_access_ctrl_lane_fmt.sv | 55 +++++
 rtl/mem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared definitions for the data-memory access controller: default data
// width, RV load/store funct3 size codes, controller state encoding and the
// alignment rule shared by the controller.
package mem_access_ctrl_pkg;

  localparam int XLEN = 32;

  // RV funct3 load/store size codes
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      MEM_H, MEM_HU: return off[0];
      MEM_W:         return |off;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Request/acknowledge data-memory port.
//   dmem_req_o   : bus request, held until dmem_ack_i
//   dmem_we_o    : 1 = write
//   dmem_addr_o  : word-aligned address
//   dmem_wdata_o : store data replicated across byte lanes
//   dmem_wstrb_o : byte strobes
//   dmem_ack_i   : transaction accepted and complete; rdata valid this cycle
//   dmem_rdata_i : read word
// master = controller side, slave = memory side.
interface mem_access_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic [3:0]      dmem_wstrb_o;
  logic            dmem_ack_i;
  logic [XLEN-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_ctrl_lane_fmt.sv
// mem_lane_fmt
// Combinational byte-lane formatting for the memory stage.
//   st_size/st_off/st_data -> st_wdata/st_wstrb : store data replicated across
//                                                 lanes plus byte strobes
//   ld_size/ld_off/ld_rdata -> ld_data          : load word shifted down to the
//                                                 addressed byte and extended
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_size,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_wstrb,
  input  logic [2:0]      ld_size,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shift;

  assign ld_shift = ld_rdata >> {ld_off, 3'b000};

  // Stores only look at size[1:0]: SB/SH/SW.
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (st_size[1:0])
      2'b00: begin
        st_wdata = {(XLEN/8){st_data[7:0]}};
        st_wstrb = 4'b0001 << st_off;
      end
      2'b01: begin
        st_wdata = {(XLEN/16){st_data[15:0]}};
        st_wstrb = 4'b0011 << st_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_shift;
    case (ld_size)
      MEM_B:   ld_data = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
      MEM_H:   ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      MEM_BU:  ld_data = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
      MEM_HU:  ld_data = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences data-memory loads/stores for the instruction at the
// execute->memory boundary and holds the result until write-back takes it.
//   clk_i, rst              : clock, synchronous active-high reset
//   execute_vaild_i, ED_*   : instruction from execute (stable while waiting)
//   write_back_allow_in_i   : downstream accepts the result this cycle
//   memory_ready_o/M_valM_o : memory-stage completion and formatted load data
//   memory_allow_in_o       : back-pressure toward execute
//   misalign_o              : current memory instruction is misaligned
//   dmem                    : request/acknowledge data-memory port (master)
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int XLEN = mem_access_ctrl_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            execute_vaild_i,
  input  logic            ED_mem_read_i,
  input  logic            ED_mem_write_i,
  input  logic [2:0]      ED_mem_size_i,
  input  logic [XLEN-1:0] ED_valE_i,
  input  logic [XLEN-1:0] ED_valB_i,
  input  logic            write_back_allow_in_i,
  output logic            memory_ready_o,
  output logic [XLEN-1:0] M_valM_o,
  output logic            memory_allow_in_o,
  output logic            misalign_o,
  mem_access_ctrl_if.master dmem
);

  state_t          state_q, state_d;
  logic            memop, mis;
  logic            issue, take, clr;
  logic            we_q;
  logic [XLEN-1:0] addr_q, wdata_q, valm_q;
  logic [3:0]      wstrb_q;
  logic [2:0]      size_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [3:0]      st_wstrb;

  assign memop = execute_vaild_i & (ED_mem_read_i | ED_mem_write_i);
  assign mis   = is_misaligned(ED_mem_size_i, ED_valE_i[1:0]);

  mem_lane_fmt #(.XLEN(XLEN)) u_fmt (
    .st_size  (ED_mem_size_i),
    .st_off   (ED_valE_i[1:0]),
    .st_data  (ED_valB_i),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_size  (size_q),
    .ld_off   (off_q),
    .ld_rdata (dmem.dmem_rdata_i),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    issue          = 1'b0;
    take           = 1'b0;
    clr            = 1'b0;
    memory_ready_o = 1'b0;
    misalign_o     = 1'b0;
    case (state_q)
      IDLE: begin
        // Misaligned accesses never reach the bus; they complete at once.
        memory_ready_o = ~(memop & ~mis);
        misalign_o     = memop & mis;
        if (memop & ~mis) begin
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmem.dmem_ack_i) begin
          if (execute_vaild_i) begin
            take    = 1'b1;
            state_d = DONE;
          end else begin
            clr     = 1'b1;
            state_d = IDLE;
          end
        end else if (!execute_vaild_i) begin
          // The bus cannot abort: keep requesting and swallow the ack.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem.dmem_ack_i) state_d = IDLE;
      end
      DONE: begin
        memory_ready_o = 1'b1;
        if (write_back_allow_in_i | ~execute_vaild_i) begin
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      valm_q  <= '0;
    end else begin
      if (issue) begin
        // Read+write together is treated as a store.
        we_q    <= ED_mem_write_i;
        addr_q  <= {ED_valE_i[XLEN-1:2], 2'b00};
        wdata_q <= ED_mem_write_i ? st_wdata : '0;
        wstrb_q <= ED_mem_write_i ? st_wstrb : 4'b0000;
        size_q  <= ED_mem_size_i;
        off_q   <= ED_valE_i[1:0];
      end
      if (take)     valm_q <= we_q ? '0 : ld_data;
      else if (clr) valm_q <= '0;
    end
  end

  assign dmem.dmem_req_o   = (state_q == REQ) | (state_q == DRAIN);
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign dmem.dmem_wstrb_o = wstrb_q;

  assign M_valM_o          = valm_q;
  assign memory_allow_in_o = ~execute_vaild_i | (memory_ready_o & write_back_allow_in_i);

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam logic [2:0] SB_ = 3'b000, SH_ = 3'b001, SW_ = 3'b010, SBU = 3'b100, SHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst, valid, rd, wr, wb;
  logic [2:0]  sz;
  logic [31:0] vale, valb;
  logic        ready, allow, mis;
  logic [31:0] valm;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.XLEN(32)) bus ();

  mem_access_ctrl #(.XLEN(32)) dut (
    .clk_i                 (clk),
    .rst                   (rst),
    .execute_vaild_i       (valid),
    .ED_mem_read_i         (rd),
    .ED_mem_write_i        (wr),
    .ED_mem_size_i         (sz),
    .ED_valE_i             (vale),
    .ED_valB_i             (valb),
    .write_back_allow_in_i (wb),
    .memory_ready_o        (ready),
    .M_valM_o              (valm),
    .memory_allow_in_o     (allow),
    .misalign_o            (mis),
    .dmem                  (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---- reference model: byte-count arithmetic, not lane muxes ----
  function automatic int nbytes(input logic [2:0] s);
    case (s)
      SB_, SBU: return 1;
      SH_, SHU: return 2;
      default:  return 4;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] s, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    return (off % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] w);
    logic [63:0] v, lim;
    int n;
    n   = nbytes(s);
    v   = {32'd0, w} >> (8 * int'(a[1:0]));
    lim = 64'd1 << (8 * n);
    v   = v % lim;
    if ((s == SB_ || s == SH_) && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] s, input logic [31:0] a);
    logic [7:0] t;
    t = ((8'd1 << nbytes(s)) - 8'd1) << a[1:0];
    return t[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] s, input logic [31:0] d);
    case (nbytes(s))
      1:       return {24'd0, d[7:0]} * 32'h0101_0101;
      2:       return {16'd0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // One complete instruction: present, serve the bus after lat wait cycles,
  // hold write-back off for stall cycles, then consume.
  task automatic do_op(input string tag, input logic r, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] vb, input logic [31:0] rdat,
                       input int lat, input int stall, input logic e_mis,
                       input logic [31:0] e_valm, input logic [3:0] e_strb, input logic [31:0] e_wd);
    logic memop;
    memop = r | w;
    @(negedge clk);
    valid = 1'b1; rd = r; wr = w; sz = s; vale = a; valb = vb; wb = 1'b1;
    #1;
    chk({tag, ".ready0"}, ready, !memop || e_mis);
    chk({tag, ".allow0"}, allow, !memop || e_mis);
    chk({tag, ".mis"},    mis,   e_mis);
    chk({tag, ".req0"},   bus.dmem_req_o, 1'b0);
    if (!memop || e_mis) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".noreq"}, bus.dmem_req_o, 1'b0);
      chk({tag, ".valm0"}, valm, 32'd0);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk({tag, ".req"},   bus.dmem_req_o, 1'b1);
      chk({tag, ".addr"},  bus.dmem_addr_o, {a[31:2], 2'b00});
      chk({tag, ".we"},    bus.dmem_we_o, w);
      chk({tag, ".rdyw"},  ready, 1'b0);
      if (w) begin
        chk({tag, ".wstrb"}, bus.dmem_wstrb_o, e_strb);
        chk({tag, ".wdata"}, bus.dmem_wdata_o, e_wd);
      end
      if (k == lat) begin
        bus.dmem_ack_i   = 1'b1;
        bus.dmem_rdata_i = rdat;
      end
      @(posedge clk);
    end
    for (int st = 0; st <= stall; st++) begin
      @(negedge clk);
      bus.dmem_ack_i   = 1'b0;
      bus.dmem_rdata_i = $urandom;
      wb = (st == stall);
      #1;
      chk({tag, ".ready"}, ready, 1'b1);
      chk({tag, ".valm"},  valm, e_valm);
      chk({tag, ".allow"}, allow, st == stall);
      chk({tag, ".reqd"},  bus.dmem_req_o, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    valid = 1'b0;
    wb = 1'b1;
    #1;
    chk({tag, ".valmclr"}, valm, 32'd0);
    chk({tag, ".readyi"},  ready, 1'b1);
  endtask

  typedef struct {
    logic        r, w;
    logic [2:0]  s;
    logic [31:0] a, vb, rdat;
    int          lat;
    logic        e_mis;
    logic [31:0] e_valm;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, SW_, 32'h0000_1000, 32'h0, 32'h0,         0, 1'b0, 32'h0,         4'h0,    32'h0};
    tbl[1]  = '{1'b1, 1'b0, SB_, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2, 1'b0, 32'hFFFF_FF80, 4'h0,    32'h0};
    tbl[2]  = '{1'b0, 1'b1, SH_, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 1'b0, 32'h0,         4'b1100, 32'hABCD_ABCD};
    tbl[3]  = '{1'b1, 1'b0, SW_, 32'h0000_1001, 32'h0, 32'h0,         0, 1'b1, 32'h0,         4'h0,    32'h0};
    tbl[4]  = '{1'b1, 1'b0, SBU, 32'h0000_1002, 32'h0, 32'h12AB_5678, 1, 1'b0, 32'h0000_00AB, 4'h0,    32'h0};
    tbl[5]  = '{1'b1, 1'b0, SH_, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 1'b0, 32'hFFFF_8001, 4'h0,    32'h0};
    tbl[6]  = '{1'b1, 1'b0, SHU, 32'h0000_0000, 32'h0, 32'h1234_F00D, 3, 1'b0, 32'h0000_F00D, 4'h0,    32'h0};
    tbl[7]  = '{1'b1, 1'b0, SW_, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF, 4'h0,    32'h0};
    tbl[8]  = '{1'b0, 1'b1, SB_, 32'h0000_1001, 32'h1234_56EF, 32'h0, 0, 1'b0, 32'h0,         4'b0010, 32'hEFEF_EFEF};
    tbl[9]  = '{1'b0, 1'b1, SW_, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D};
    tbl[10] = '{1'b1, 1'b0, SHU, 32'h0000_0003, 32'h0, 32'h0,         0, 1'b1, 32'h0,         4'h0,    32'h0};
    tbl[11] = '{1'b1, 1'b1, SB_, 32'h0000_0003, 32'h0000_007A, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, 4'b1000, 32'h7A7A_7A7A};
    tbl[12] = '{1'b1, 1'b0, SB_, 32'h0000_0000, 32'h0, 32'h0000_007F, 0, 1'b0, 32'h0000_007F, 4'h0,    32'h0};

    rst = 1'b1; valid = 1'b0; rd = 1'b0; wr = 1'b0; sz = 3'b0; vale = '0; valb = '0; wb = 1'b1;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req",   bus.dmem_req_o, 1'b0);
    chk("rst.we",    bus.dmem_we_o, 1'b0);
    chk("rst.addr",  bus.dmem_addr_o, 32'd0);
    chk("rst.wdata", bus.dmem_wdata_o, 32'd0);
    chk("rst.wstrb", bus.dmem_wstrb_o, 4'd0);
    chk("rst.valm",  valm, 32'd0);
    chk("rst.mis",   mis, 1'b0);
    chk("rst.ready", ready, 1'b1);
    chk("rst.allow", allow, 1'b1);
    rst = 1'b0;

    foreach (tbl[i])
      do_op($sformatf("tbl%0d", i), tbl[i].r, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].vb, tbl[i].rdat,
            tbl[i].lat, 0, tbl[i].e_mis, tbl[i].e_valm, tbl[i].e_strb, tbl[i].e_wd);

    // LW held in DONE while write-back stalls for 3 cycles
    do_op("stall", 1'b1, 1'b0, SW_, 32'h0000_0040, 32'h0, 32'h1357_9BDF, 0, 3, 1'b0,
          32'h1357_9BDF, 4'h0, 32'h0);

    // execute drops during REQ; ack arrives 4 cycles later and is swallowed
    @(negedge clk);
    valid = 1'b1; rd = 1'b1; wr = 1'b0; sz = SW_; vale = 32'h0000_0100; wb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drain.req0", bus.dmem_req_o, 1'b1);
    valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain.req",   bus.dmem_req_o, 1'b1);
      chk("drain.addr",  bus.dmem_addr_o, 32'h0000_0100);
      chk("drain.ready", ready, 1'b0);
      chk("drain.valm",  valm, 32'd0);
      if (k == 3) begin bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h5555_AAAA; end
      @(posedge clk);
    end
    @(negedge clk);
    bus.dmem_ack_i = 1'b0;
    chk("drain.idle_req",   bus.dmem_req_o, 1'b0);
    chk("drain.idle_ready", ready, 1'b1);
    chk("drain.idle_valm",  valm, 32'd0);

    // ack on the same edge execute drops: result discarded
    valid = 1'b1; rd = 1'b1; sz = SW_; vale = 32'h0000_0200;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    bus.dmem_ack_i = 1'b0;
    chk("flush.req",   bus.dmem_req_o, 1'b0);
    chk("flush.ready", ready, 1'b1);
    chk("flush.valm",  valm, 32'd0);

    // reset while REQ; late ack must be ignored
    valid = 1'b1; rd = 1'b1; sz = SW_; vale = 32'h0000_0300;
    @(posedge clk);
    @(negedge clk);
    chk("rstreq.req1", bus.dmem_req_o, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    chk("rstreq.req0", bus.dmem_req_o, 1'b0);
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    bus.dmem_ack_i = 1'b0;
    chk("rstreq.late_req",   bus.dmem_req_o, 1'b0);
    chk("rstreq.late_valm",  valm, 32'd0);
    chk("rstreq.late_ready", ready, 1'b1);
    do_op("after_rst", 1'b1, 1'b0, SH_, 32'h0000_0306, 32'h0, 32'h7FFF_0000, 0, 0, 1'b0,
          32'h0000_7FFF, 4'h0, 32'h0);

    // randomized instructions against the model
    for (int i = 0; i < 150; i++) begin
      logic        r, w, em;
      logic [2:0]  s;
      logic [31:0] a, vb, rdat;
      logic [2:0]  ld_sz[5];
      int          kind;
      ld_sz = '{SB_, SH_, SW_, SBU, SHU};
      kind = int'($urandom_range(0, 3));
      r = (kind == 1) || (kind == 3);
      w = (kind == 2) || (kind == 3);
      s = w ? ld_sz[$urandom_range(0, 2)] : ld_sz[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      vb = $urandom;
      rdat = $urandom;
      em = (r | w) && ref_mis(s, a);
      do_op($sformatf("rnd%0d", i), r, w, s, a, vb, rdat, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)), em, w ? 32'd0 : ref_load(s, a, rdat),
            ref_strb(s, a), ref_wdata(s, vb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
